// File: rtl/mult_accumulator_pkg.sv
// Shared definitions for the multiply-accumulate stage: default widths,
// FSM state encoding and saturation-limit helpers.
package mult_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_ACC_WIDTH  = 16;
    localparam int DEF_CNT_WIDTH  = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_ACCUM = ACCUM,
        ST_HOLD  = HOLD
    } state_e;

    // Largest two's complement value of a w-bit word, as a 64-bit pattern.
    function automatic logic [63:0] signed_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's complement value of a w-bit word (bit pattern 100..0).
    function automatic logic [63:0] signed_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

    // Largest unsigned value of a w-bit word.
    function automatic logic [63:0] unsigned_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/mult_accumulator_if.sv
// Product-in / result-out handshake bundle for the accumulator stage.
// The producer/consumer side uses master; the accumulator uses slave.
interface mult_accumulator_if
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic [2*DATA_WIDTH-1:0] in_product;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_WIDTH-1:0]    out_data;
    logic [CNT_WIDTH-1:0]    out_count;
    logic                    out_overflow;

    modport master (
        output in_valid,
        output in_product,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_count,
        input  out_overflow
    );

    modport slave (
        input  in_valid,
        input  in_product,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_count,
        output out_overflow
    );

endinterface

// File: rtl/mult_accumulator_sat_adder.sv
// Combinational extend + add + clamp for the accumulator. The addition is
// done one bit wider than the accumulator so the true sum is always known
// before it is clamped into range.
module sat_adder
    import mult_pkg::*;
#(
    parameter int PROD_WIDTH = 2 * DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter bit SIGNED     = 1'b1
) (
    input  logic [ACC_WIDTH-1:0]  acc_i,
    input  logic [PROD_WIDTH-1:0] product_i,
    output logic [ACC_WIDTH-1:0]  sum_o,
    output logic                  ovf_o
);

    localparam int EXT_WIDTH = ACC_WIDTH + 1;

    localparam logic [63:0] SMAX_W = signed_max(ACC_WIDTH);
    localparam logic [63:0] SMIN_W = signed_min(ACC_WIDTH);
    localparam logic [63:0] UMAX_W = unsigned_max(ACC_WIDTH);

    localparam logic [ACC_WIDTH-1:0] SMAX = SMAX_W[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] SMIN = SMIN_W[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] UMAX = UMAX_W[ACC_WIDTH-1:0];

    logic [EXT_WIDTH-1:0] acc_ext;
    logic [EXT_WIDTH-1:0] prod_ext;
    logic [EXT_WIDTH-1:0] raw_sum;

    // Widen both operands by the signedness rule and form the unclamped sum
    always_comb begin
        if (SIGNED) begin
            acc_ext  = {acc_i[ACC_WIDTH-1], acc_i};
            prod_ext = {{(EXT_WIDTH-PROD_WIDTH){product_i[PROD_WIDTH-1]}}, product_i};
        end else begin
            acc_ext  = {1'b0, acc_i};
            prod_ext = {{(EXT_WIDTH-PROD_WIDTH){1'b0}}, product_i};
        end
        raw_sum = acc_ext + prod_ext;
    end

    // Clamp the wide sum into the accumulator range and flag any clamp
    always_comb begin
        sum_o = raw_sum[ACC_WIDTH-1:0];
        ovf_o = 1'b0;
        if (SIGNED) begin
            // Top two bits disagree only when the result left the signed range
            if (raw_sum[ACC_WIDTH] != raw_sum[ACC_WIDTH-1]) begin
                ovf_o = 1'b1;
                sum_o = raw_sum[ACC_WIDTH] ? SMIN : SMAX;
            end else begin
                ovf_o = 1'b0;
                sum_o = raw_sum[ACC_WIDTH-1:0];
            end
        end else begin
            // Only an upward carry is possible when both operands are unsigned
            if (raw_sum[ACC_WIDTH]) begin
                ovf_o = 1'b1;
                sum_o = UMAX;
            end else begin
                ovf_o = 1'b0;
                sum_o = raw_sum[ACC_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mult_accumulator.sv
// Saturating dot-product accumulator downstream of the array multiplier.
// Beats are summed until in_last, then the result is held on the output
// handshake with its beat count and a sticky overflow flag.
module mult_accumulator
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter bit SIGNED     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    mult_accumulator_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_e               state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ovf_q;
    logic                 out_valid_q;
    logic [ACC_WIDTH-1:0] out_data_q;
    logic [CNT_WIDTH-1:0] out_count_q;
    logic                 out_overflow_q;

    logic                 in_ready_int;
    logic                 beat_accept;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 sat_ovf;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 ovf_d;

    sat_adder #(
        .PROD_WIDTH (2 * DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED     (SIGNED)
    ) u_sat_adder (
        .acc_i     (acc_q),
        .product_i (bus.in_product),
        .sum_o     (acc_d),
        .ovf_o     (sat_ovf)
    );

    // Acceptance, saturating beat count and sticky overflow for the next beat
    always_comb begin
        in_ready_int = (state_q != ST_HOLD) && !clear;
        beat_accept  = bus.in_valid && in_ready_int;
        if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        ovf_d = ovf_q | sat_ovf;
    end

    // FSM with accumulator and registered result; reset and clear both empty it
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q        <= ST_IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_count_q    <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (beat_accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        if (bus.in_last) begin
                            state_q        <= ST_HOLD;
                            out_valid_q    <= 1'b1;
                            out_data_q     <= acc_d;
                            out_count_q    <= cnt_d;
                            out_overflow_q <= ovf_d;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result leaves on the handshake; the next beat waits a cycle
                    if (bus.out_ready) begin
                        state_q        <= ST_IDLE;
                        acc_q          <= '0;
                        cnt_q          <= '0;
                        ovf_q          <= 1'b0;
                        out_valid_q    <= 1'b0;
                        out_data_q     <= '0;
                        out_count_q    <= '0;
                        out_overflow_q <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    acc_q          <= '0;
                    cnt_q          <= '0;
                    ovf_q          <= 1'b0;
                    out_valid_q    <= 1'b0;
                    out_data_q     <= '0;
                    out_count_q    <= '0;
                    out_overflow_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_int;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_count    = out_count_q;
    assign bus.out_overflow = out_overflow_q;

endmodule
